// File: rtl/conway_stream_engine.sv
// rtl/conway_stream_engine.sv - streaming next-generation engine for Conway-style cellular automata
//
// Consumes one cell per accepted input beat in raster order and emits the next
// generation in the same order. Two 1-bit line buffers plus a 3x3 shift window
// form the neighbourhood. The birth/survive rule masks are latched at frame start.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   birth_mask, survive_mask   rule masks indexed by live-neighbour count
//   s_valid/s_ready/s_data     input cell stream
//   m_valid/m_ready/m_data     output cell stream
//   m_first, m_last            qualify output cells (0,0) and (H-1,W-1)
//   frame_done                 pulse on the cycle m_last is accepted
//   busy                       first accepted input until frame_done
//   population                 live cells of the last completed frame
//                              (present only when POPULATION_COUNT_EN is defined)
module conway_stream_engine #(
  parameter int WIDTH_PIXELS  = 64,
  parameter int HEIGHT_PIXELS = 48,
  parameter int COL_WIDTH     = $clog2(WIDTH_PIXELS),
  parameter int ROW_WIDTH     = $clog2(HEIGHT_PIXELS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] birth_mask,
  input  logic [8:0] survive_mask,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_data,
  output logic       m_first,
  output logic       m_last,
  output logic       frame_done,
`ifdef POPULATION_COUNT_EN
  output logic [$clog2(WIDTH_PIXELS*HEIGHT_PIXELS+1)-1:0] population,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(WIDTH_PIXELS - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(HEIGHT_PIXELS - 1);

  state_t                 state_q, state_d;
  logic [COL_WIDTH-1:0]   in_col_q, in_col_d, out_col_q, out_col_d;
  logic [ROW_WIDTH-1:0]   in_row_q, in_row_d, out_row_q, out_row_d;
  logic [8:0]             birth_q, birth_d, survive_q, survive_d;
  logic [2:0]             win_l_q, win_l_d, win_c_q, win_c_d;
  logic                   m_valid_q, m_valid_d, m_data_q, m_data_d;
  logic                   m_first_q, m_first_d, m_last_q, m_last_d;
  logic                   busy_q, busy_d;

  logic lb0_mem [WIDTH_PIXELS];
  logic lb1_mem [WIDTH_PIXELS];

  logic       in_phase, out_free, advance, produce, s_in;
  logic       lb0_rd, lb1_rd;
  logic [2:0] new_col, row_mask, l_m, c_m, r_m;
  logic       left_ok, right_ok;
  logic [3:0] n_live;
  logic       next_cell;

  assign in_phase   = (state_q != FLUSH);
  assign out_free   = !m_valid_q || m_ready;
  assign s_ready    = !reset && in_phase && out_free;
  assign advance    = in_phase ? (s_valid && s_ready) : (out_free && !reset);
  assign produce    = advance && (state_q == RUN || state_q == FLUSH);
  // Flush ticks shift in dead cells so the last rows see a zero bottom edge.
  assign s_in       = in_phase && s_data;

  // Read-before-write: lb0 holds row r-1, lb1 holds row r-2 at this column.
  assign lb0_rd  = lb0_mem[in_col_q];
  assign lb1_rd  = lb1_mem[in_col_q];
  assign new_col = {s_in, lb0_rd, lb1_rd};  // bit0 = top, bit2 = bottom

  // Masking is keyed on the centre coordinates, which also hides the
  // previous row's cells that wrap into the window at column edges.
  assign row_mask = {out_row_q != ROW_LAST, 1'b1, out_row_q != '0};
  assign left_ok  = (out_col_q != '0);
  assign right_ok = (out_col_q != COL_LAST);
  assign l_m      = win_l_q & row_mask & {3{left_ok}};
  assign c_m      = win_c_q & row_mask;
  assign r_m      = new_col & row_mask & {3{right_ok}};

  assign n_live = 4'(l_m[0]) + 4'(l_m[1]) + 4'(l_m[2]) + 4'(c_m[0]) + 4'(c_m[2])
                + 4'(r_m[0]) + 4'(r_m[1]) + 4'(r_m[2]);
  assign next_cell = win_c_q[1] ? survive_q[n_live] : birth_q[n_live];

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_first    = m_first_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign frame_done = !reset && m_valid_q && m_ready && m_last_q;

  always_comb begin
    state_d   = state_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    birth_d   = birth_q;
    survive_d = survive_q;
    win_l_d   = win_l_q;
    win_c_d   = win_c_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_first_d = m_first_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;

    if (advance) begin
      win_l_d = win_c_q;
      win_c_d = new_col;
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        if (in_phase) in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end

    if (produce) begin
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: if (advance) begin
        state_d   = FILL;
        birth_d   = birth_mask;
        survive_d = survive_mask;
      end
      // Beat W (row 1, col 0) is the last one before outputs start.
      FILL: if (advance && in_row_q == ROW_WIDTH'(1) && in_col_q == '0) state_d = RUN;
      RUN:  if (advance && in_row_q == ROW_LAST && in_col_q == COL_LAST) state_d = FLUSH;
      FLUSH: if (advance && out_row_q == ROW_LAST && out_col_q == COL_LAST) begin
        state_d  = IDLE;
        in_col_d = '0;
        in_row_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (produce) begin
      m_valid_d = 1'b1;
      m_data_d  = next_cell;
      m_first_d = (out_row_q == '0) && (out_col_q == '0);
      m_last_d  = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (state_q == IDLE && advance) busy_d = 1'b1;
    else if (frame_done)            busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      birth_q   <= '0;
      survive_q <= '0;
      win_l_q   <= '0;
      win_c_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      birth_q   <= birth_d;
      survive_q <= survive_d;
      win_l_q   <= win_l_d;
      win_c_q   <= win_c_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
    end
  end

  // Line buffers are deliberately left unreset; edge masking hides stale cells.
  always_ff @(posedge clk) begin
    if (advance) begin
      lb0_mem[in_col_q] <= s_in;
      lb1_mem[in_col_q] <= lb0_rd;
    end
  end

`ifdef POPULATION_COUNT_EN
  localparam int POP_WIDTH = $clog2(WIDTH_PIXELS*HEIGHT_PIXELS+1);

  logic [POP_WIDTH-1:0] pop_acc_q, pop_acc_d, population_q, population_d;

  assign population = population_q;

  always_comb begin
    pop_acc_d    = pop_acc_q;
    population_d = population_q;
    if (m_valid_q && m_ready) begin
      if (m_last_q) begin
        population_d = pop_acc_q + POP_WIDTH'(m_data_q);
        pop_acc_d    = '0;
      end else begin
        pop_acc_d = pop_acc_q + POP_WIDTH'(m_data_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_acc_q    <= '0;
      population_q <= '0;
    end else begin
      pop_acc_q    <= pop_acc_d;
      population_q <= population_d;
    end
  end
`endif

endmodule

// File: doc/conway_stream_engine.md
Name: conway_stream_engine

Overview:
- Streaming next-generation engine for Conway-style cellular automata.
- Consumes one cell per accepted beat of the current generation, raster order (row 0 col 0 first), over a valid/ready input.
- Emits the next generation in the same order over a valid/ready output.
- Successor to the nine-BRAM/centre-select data path: two line buffers plus a 3x3 window, runtime birth/survive rule masks, backpressure and frame framing.
- Sits between frame-buffer read DMA and frame-buffer write logic.

Parameters:
- WIDTH_PIXELS, 64, cells per row (>=3).
- HEIGHT_PIXELS, 48, rows per frame (>=3).
- COL_WIDTH, $clog2(WIDTH_PIXELS), column counter width.
- ROW_WIDTH, $clog2(HEIGHT_PIXELS), row counter width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- birth_mask  in  9  bit n set: dead cell with n live neighbours becomes live.
- survive_mask  in  9  bit n set: live cell with n live neighbours stays live.
- s_valid  in  1  input cell valid.
- s_ready  out  1  engine accepts input cell.
- s_data  in  1  input cell state.
- m_valid  out  1  output cell valid.
- m_ready  in  1  downstream accepts output cell.
- m_data  out  1  next-generation cell state.
- m_first  out  1  qualifies output cell (0,0).
- m_last  out  1  qualifies output cell (H-1,W-1).
- frame_done  out  1  one-cycle pulse on the cycle m_last is accepted.
- busy  out  1  high from first accepted input until frame_done.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, m_first=0, m_last=0, frame_done=0, busy=0. All counters 0; state IDLE.
- Line-buffer contents are not reset. Correctness relies on masking only.
- States:
  - IDLE: s_ready=1. First accepted beat goes to FILL, latches birth_mask/survive_mask for the whole frame, and sets busy.
  - FILL: until W+1 input beats have been accepted. No output.
  - RUN: every accepted input produces one output.
  - FLUSH: entered after beat W*H is accepted. s_ready=0. Engine self-ticks with s_data treated as 0 for W+1 ticks. After the last flush tick it returns to IDLE.
- Tick condition: advance = (in_phase ? s_valid & s_ready : FLUSH) & (!m_valid | m_ready).
  - s_ready = (IDLE|FILL|RUN) & (!m_valid | m_ready).
  - s_ready must not depend combinationally on s_valid.
- Output register:
  - On an output-producing tick, m_valid<=1 and m_data/m_first/m_last are loaded.
  - On m_valid & m_ready with no new tick, m_valid<=0.
  - m_data, m_first and m_last hold while m_valid & !m_ready.
- Latency: output cell (r,c) is produced on the tick that consumes input (r+1,c+1), or the equivalent flush tick. That is W+1 ticks behind input, plus one register stage.
- Window: 3x3 shift registers fed by line buffer 1 (row r-1), line buffer 0 (row r) and the incoming cell.
  - Line buffers are 1-bit, depth WIDTH_PIXELS.
  - Write at column index; read-before-write each tick.
- Boundary: no wrap. Neighbours with row<0, row>=H, col<0 or col>=W are forced to 0 by row/col masking of the centre-cell coordinates. Column wrap of the shift window must never leak the previous row's cells.
- Rule: n = popcount of 8 neighbours (4-bit, 0..8). next = centre ? survive_mask[n] : birth_mask[n]. Default Conway is birth=9'h008, survive=9'h00C.
- Mask changes mid-frame have no effect until the next IDLE->FILL.
- Back-to-back frames: the first beat of frame N+1 is not accepted until FLUSH of frame N completes. No inter-frame state carries over.
- Reset mid-frame: next cycle outputs are at reset values. The partially sent frame is abandoned with no m_last or frame_done. The next accepted beat is treated as (0,0).
- Simultaneous m_ready and new tick: output register reloads the same cycle with no bubble. Full throughput is 1 cell/cycle.

Optional Feature:
- Macro POPULATION_COUNT_EN.
- When defined, adds output port population (width $clog2(WIDTH_PIXELS*HEIGHT_PIXELS+1)).
  - Counts live output cells as they are accepted.
  - Value updates to the frame total on the frame_done cycle and holds until the next frame_done.
  - Reset value is 0.
- When undefined: port, counter and all related logic are absent. Behaviour is otherwise identical.

Test Plan:
- 5x5, default rule, horizontal blinker at row 2 cols 1..3, m_ready=1 -> output vertical blinker at col 2 rows 1..3, all else 0. m_first on beat 0, m_last on beat 24, one frame_done; first m_valid 7 cycles after first accept.
- 6x6 block still life at (0,0)-(1,1), plus a single live cell at (5,5) -> block unchanged; corner cell dies. No wrap effects at edges.
- 8x8 random fill, random s_valid and random m_ready at 50% -> output matches golden model bit-exact. No beat dropped or duplicated; m_data stable while stalled.
- Reset asserted after 20 accepted beats of an 8x8 frame, then a full frame sent -> m_valid=0 the cycle after reset. Second frame output is correct, with exactly one frame_done.
- HighLife masks birth=9'h048, survive=9'h00C, changed to Conway mid-frame -> current frame uses HighLife throughout; next frame uses Conway.
- POPULATION_COUNT_EN, 5x5 blinker for two frames -> population=3 after each frame_done; value holds between frames.
